// File: rtl/vga_pixel_fetch.sv
// ---------------------------------------------------------------------------
// vga_pixel_fetch
//
// Turns monochrome framebuffer words into a 1-bit VGA pixel stream. The block
// sits behind the VGA timing generator. For each SE line it fetches
// WORDS_PER_LINE 16-bit words from video RAM over a req/ack handshake. The
// words pass through a 2-entry prefetch FIFO and are shifted out MSB-first,
// one bit per pixel. Sync and blanking are delayed so they stay aligned with
// the serialised pixels.
//
// Ports
//   pixClk      pixel clock, the only clock
//   reset       synchronous, active-high reset
//   hCount      horizontal pixel count from the timing generator
//   vCount      vertical line count from the timing generator
//   hActive     VGA horizontal active
//   vActive     VGA vertical active
//   hSEActive   SE horizontal window (512 px, starts where hCount[3:0]==0)
//   vSEActive   SE vertical window
//   nhSync      horizontal sync, active-low
//   nvSync      vertical sync, active-low
//   vidReq      video RAM read request
//   vidAddr     video RAM word address, held steady while vidReq is high
//   vidAck      single-cycle read acknowledge; vidData is valid in that cycle
//   vidData     RAM read data, a 1 bit means a black pixel
//   pixOut      VGA pixel, 1 means white
//   nhSyncOut   nhSync delayed by 2 cycles
//   nvSyncOut   nvSync delayed by 2 cycles
//   underrun    sticky flag: a word was needed while the FIFO was empty
// ---------------------------------------------------------------------------
module vga_pixel_fetch #(
   parameter int SE_ROWS        = 342,
   parameter int WORDS_PER_LINE = 32,
   parameter int BASE_ADDR      = 0
) (
   input  logic        pixClk,
   input  logic        reset,
   input  logic [9:0]  hCount,
   input  logic [9:0]  vCount,
   input  logic        hActive,
   input  logic        vActive,
   input  logic        hSEActive,
   input  logic        vSEActive,
   input  logic        nhSync,
   input  logic        nvSync,
   output logic        vidReq,
   output logic [13:0] vidAddr,
   input  logic        vidAck,
   input  logic [15:0] vidData,
   output logic        pixOut,
   output logic        nhSyncOut,
   output logic        nvSyncOut,
   output logic        underrun
);

   localparam int              WCW       = $clog2(WORDS_PER_LINE + 1);
   localparam logic [WCW-1:0]  WPL_CNT   = WCW'(WORDS_PER_LINE);
   localparam logic [9:0]      SE_ROWS_V = 10'(SE_ROWS);
   localparam logic [13:0]     BASE_A    = 14'(BASE_ADDR);
   localparam logic [13:0]     WPL_A     = 14'(WORDS_PER_LINE);

   typedef enum logic {IDLE, REQ} FetchState;

   FetchState        state;
   FetchState        stateNext;
   logic             nhSyncPrev;
   logic             lineStart;
   logic [9:0]       lineReg;
   logic             lineEn;
   logic [WCW-1:0]   wordCnt;
   logic [13:0]      addrNext;
   logic [15:0]      fifoMem [2];
   logic             rdPtr;
   logic             wrPtr;
   logic [1:0]       fifoCount;
   logic             push;
   logic             pop;
   logic             loadNow;
   logic [15:0]      shiftReg;
   logic             seActD1;
   logic             vgaActD1;
   logic             nhSyncD1;
   logic             nvSyncD1;
   logic             unusedHCount;

   // Only the low nibble of hCount matters: it marks the 16-pixel word
   // boundaries inside the SE window. The upper bits are folded here so
   // they are visibly consumed.
   assign unusedHCount = ^hCount[9:4];

   // A new line begins on the rising edge of nhSync, which is the end of the
   // sync pulse. The registered copy resets high so that leaving reset with
   // nhSync high does not look like an edge.
   always_ff @(posedge pixClk) begin
      if (reset) begin
         nhSyncPrev <= 1'b1;
      end else begin
         nhSyncPrev <= nhSync;
      end
   end

   assign lineStart = nhSync && !nhSyncPrev;

   // A word is accepted only while a request is outstanding. Line start wins
   // over both FIFO operations, so an ack that arrives during line start is
   // dropped. The load at each 16-pixel boundary of an SE line pops the FIFO.
   // Loads are gated by lineEn, so lines without fetched data never consume
   // words and never raise underrun.
   assign push    = (state == REQ) && vidAck && !lineStart;
   assign loadNow = hSEActive && vSEActive && lineEn && (hCount[3:0] == 4'd0);
   assign pop     = loadNow && (fifoCount != 2'd0) && !lineStart;

   // Per-line bookkeeping: latch the line number and whether the line has
   // SE data, then count the words accepted on this line.
   always_ff @(posedge pixClk) begin
      if (reset) begin
         lineReg <= '0;
         lineEn  <= 1'b0;
         wordCnt <= '0;
      end else if (lineStart) begin
         lineReg <= vCount;
         lineEn  <= (vCount < SE_ROWS_V);
         wordCnt <= '0;
      end else if (push) begin
         wordCnt <= wordCnt + WCW'(1);
      end
   end

   // The RAM address is registered from lineReg and wordCnt. Every request
   // is preceded by at least one IDLE cycle, so the address has settled
   // before vidReq rises and it stays steady for the whole request.
   assign addrNext = BASE_A + 14'(lineReg) * WPL_A + 14'(wordCnt);

   always_ff @(posedge pixClk) begin
      if (reset) begin
         vidAddr <= '0;
      end else begin
         vidAddr <= addrNext;
      end
   end

   // Fetch FSM state register.
   always_ff @(posedge pixClk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Fetch FSM next state. A request starts only when the FIFO has room,
   // so a push can never overflow it. After each ack the FSM returns to
   // IDLE for at least one cycle, which gives the address time to update.
   always_comb begin
      stateNext = state;
      vidReq    = 1'b0;
      case (state)
         IDLE: begin
            if (lineEn && (wordCnt < WPL_CNT) && (fifoCount < 2'd2) && !lineStart) begin
               stateNext = REQ;
            end
         end
         REQ: begin
            vidReq = 1'b1;
            if (lineStart || vidAck) begin
               stateNext = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Prefetch FIFO pointers and occupancy. Line start flushes the FIFO.
   // A simultaneous push and pop advances both pointers and leaves the
   // count unchanged.
   always_ff @(posedge pixClk) begin
      if (reset || lineStart) begin
         rdPtr     <= 1'b0;
         wrPtr     <= 1'b0;
         fifoCount <= 2'd0;
      end else begin
         if (push) begin
            wrPtr <= !wrPtr;
         end
         if (pop) begin
            rdPtr <= !rdPtr;
         end
         case ({push, pop})
            2'b10:   fifoCount <= fifoCount + 2'd1;
            2'b01:   fifoCount <= fifoCount - 2'd1;
            default: fifoCount <= fifoCount;
         endcase
      end
   end

   // FIFO storage holds only data, so it needs no reset.
   always_ff @(posedge pixClk) begin
      if (push) begin
         fifoMem[wrPtr] <= vidData;
      end
   end

   // Serialiser, stage 1. At each word boundary the FIFO head is loaded. If
   // the FIFO is empty, black is loaded and underrun latches. Between loads
   // the register shifts left and fills with 1s, so anything past the end
   // of a word reads as black. The window and sync flags are delayed by the
   // same stage.
   always_ff @(posedge pixClk) begin
      if (reset) begin
         shiftReg <= 16'hFFFF;
         underrun <= 1'b0;
         seActD1  <= 1'b0;
         vgaActD1 <= 1'b0;
         nhSyncD1 <= 1'b1;
         nvSyncD1 <= 1'b1;
      end else begin
         if (loadNow) begin
            if (fifoCount == 2'd0) begin
               shiftReg <= 16'hFFFF;
               underrun <= 1'b1;
            end else begin
               shiftReg <= fifoMem[rdPtr];
            end
         end else begin
            shiftReg <= {shiftReg[14:0], 1'b1};
         end
         seActD1  <= hSEActive && vSEActive && lineEn;
         vgaActD1 <= hActive && vActive;
         nhSyncD1 <= nhSync;
         nvSyncD1 <= nvSync;
      end
   end

   // Output stage 2. Pixels inside the SE window follow the shift register
   // (a RAM 1 gives black). The rest of the VGA active area is a white
   // border, and blanking is black.
   always_ff @(posedge pixClk) begin
      if (reset) begin
         pixOut    <= 1'b0;
         nhSyncOut <= 1'b1;
         nvSyncOut <= 1'b1;
      end else begin
         pixOut    <= vgaActD1 && !(seActD1 && shiftReg[15]);
         nhSyncOut <= nhSyncD1;
         nvSyncOut <= nvSyncD1;
      end
   end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// ---------------------------------------------------------------------------
// tb_vga_pixel_fetch
//
// Testbench for vga_pixel_fetch, built around scoreboards. Each stimulus
// cycle pushes the expected pixel and sync values into a queue, tagged with
// the cycle in which they must appear. Each line start pushes the expected
// RAM addresses. Independent monitors pop those queues and compare whenever
// the DUT presents a pixel or raises a new request. A small RAM model
// answers requests two cycles after they are raised.
// ---------------------------------------------------------------------------
module tb_vga_pixel_fetch;

   logic        pixClk;
   logic        reset;
   logic [9:0]  hCount;
   logic [9:0]  vCount;
   logic        hActive;
   logic        vActive;
   logic        hSEActive;
   logic        vSEActive;
   logic        nhSync;
   logic        nvSync;
   logic        vidReq;
   logic [13:0] vidAddr;
   logic        vidAck;
   logic [15:0] vidData;
   logic        pixOut;
   logic        nhSyncOut;
   logic        nvSyncOut;
   logic        underrun;

   typedef struct {
      int   cyc;
      logic pix;
      logic hs;
      logic vs;
   } PixExp;

   PixExp       pixQ[$];
   logic [13:0] addrQ[$];

   int   vectors     = 0;
   int   miscompares = 0;
   int   cycleCnt    = 0;
   int   reqCount    = 0;
   int   pushCount   = 0;
   int   popCount    = 0;
   int   maxBuf      = 0;
   int   ramAge      = 0;
   logic ramEn       = 1'b0;

   vga_pixel_fetch #(
      .SE_ROWS(342),
      .WORDS_PER_LINE(32),
      .BASE_ADDR(0)
   ) dut (
      .pixClk(pixClk),
      .reset(reset),
      .hCount(hCount),
      .vCount(vCount),
      .hActive(hActive),
      .vActive(vActive),
      .hSEActive(hSEActive),
      .vSEActive(vSEActive),
      .nhSync(nhSync),
      .nvSync(nvSync),
      .vidReq(vidReq),
      .vidAddr(vidAddr),
      .vidAck(vidAck),
      .vidData(vidData),
      .pixOut(pixOut),
      .nhSyncOut(nhSyncOut),
      .nvSyncOut(nvSyncOut),
      .underrun(underrun)
   );

   // Free-running pixel clock.
   initial begin
      pixClk = 1'b0;
      forever #5 pixClk = ~pixClk;
   end

   // Cycle index, advanced on every active edge.
   initial begin
      forever begin
         @(posedge pixClk);
         cycleCnt++;
      end
   end

   // Contents of the video RAM. Word 160 (line 5, word 0) holds the known
   // pattern A5F0. Every other word is derived from its own address.
   function automatic logic [15:0] ramWord(input logic [13:0] a);
      if (a == 14'd160) begin
         return 16'hA5F0;
      end
      return {a[7:0] ^ 8'h3C, a[7:0]};
   endfunction

   // Common comparison: counts every check and reports any miscompare.
   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%h, expected 0x%h",
                  name, cycleCnt, actual, expected);
      end
   endtask

   // Drive one cycle of timing-generator inputs. The expected pixel and syncs
   // are queued for two cycles later. The task returns just after the edge
   // that samples the inputs.
   task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v,
                                input logic ha, input logic va, input logic hse,
                                input logic vse, input logic nh, input logic nv,
                                input logic expPix);
      PixExp e;
      hCount    = h;
      vCount    = v;
      hActive   = ha;
      vActive   = va;
      hSEActive = hse;
      vSEActive = vse;
      nhSync    = nh;
      nvSync    = nv;
      e.cyc = cycleCnt + 2;
      e.pix = expPix;
      e.hs  = nh;
      e.vs  = nv;
      pixQ.push_back(e);
      @(posedge pixClk);
      #1;
   endtask

   // Blanking cycles: everything inactive, so the pixel is black.
   task automatic blankCycles(input int n, input logic [9:0] v);
      for (int i = 0; i < n; i++) begin
         applyStimulus(10'd700, v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      end
   endtask

   // VGA active but outside the SE window: white border.
   task automatic borderCycles(input int n, input logic [9:0] v);
      for (int i = 0; i < n; i++) begin
         applyStimulus(10'(600 + i), v, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      end
   endtask

   // Sync pulse followed by the nhSync rising edge that starts line v.
   task automatic lineStartSeq(input logic [9:0] v);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(10'd660, v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      applyStimulus(10'd700, v, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
   endtask

   // Sweep the SE window for nWords words. Mode 0 expects the RAM contents
   // of line v, mode 1 expects black (empty FIFO) and mode 2 expects white
   // (a line with no SE data).
   task automatic seWindow(input int nWords, input logic [9:0] v, input int mode);
      logic [15:0] word;
      logic        expPix;
      for (int w = 0; w < nWords; w++) begin
         word = ramWord(14'(int'(v) * 32 + w));
         for (int b = 0; b < 16; b++) begin
            case (mode)
               0:       expPix = !word[15 - b];
               1:       expPix = 1'b0;
               default: expPix = 1'b1;
            endcase
            if (mode == 0 && b == 0) begin
               popCount++;
            end
            applyStimulus(10'(w * 16 + b), v, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, expPix);
         end
      end
   endtask

   // Pixel monitor: compares the pixel and both syncs whenever a queued
   // expectation falls due.
   initial begin
      PixExp e;
      forever begin
         @(negedge pixClk);
         if (pixQ.size() > 0 && pixQ[0].cyc == cycleCnt) begin
            e = pixQ.pop_front();
            checkOutput("pixel/hs/vs", {13'd0, pixOut, nhSyncOut, nvSyncOut},
                        {13'd0, e.pix, e.hs, e.vs});
         end
      end
   end

   // Request monitor: every new request must carry the next expected address.
   initial begin
      logic prevReq;
      prevReq = 1'b0;
      forever begin
         @(negedge pixClk);
         if (vidReq === 1'b1 && prevReq !== 1'b1) begin
            reqCount++;
            if (addrQ.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL reqAddr at cycle %0d: got request for %0d, expected no request",
                        cycleCnt, vidAddr);
            end else begin
               checkOutput("reqAddr", 16'(vidAddr), 16'(addrQ.pop_front()));
            end
         end
         prevReq = vidReq;
      end
   end

   // RAM model: acknowledges a request in its third cycle, i.e. two cycles
   // after vidReq rises, and records how many words the DUT holds at most.
   initial begin
      forever begin
         @(negedge pixClk);
         if (ramEn) begin
            if (vidReq === 1'b1) begin
               ramAge++;
            end else begin
               ramAge = 0;
            end
            if (vidReq === 1'b1 && ramAge == 3) begin
               vidAck  = 1'b1;
               vidData = ramWord(vidAddr);
               pushCount++;
               if (pushCount - popCount > maxBuf) begin
                  maxBuf = pushCount - popCount;
               end
            end else begin
               vidAck = 1'b0;
            end
         end
      end
   end

   // Main stimulus sequence.
   initial begin
      reset     = 1'b1;
      hCount    = '0;
      vCount    = '0;
      hActive   = 1'b0;
      vActive   = 1'b0;
      hSEActive = 1'b0;
      vSEActive = 1'b0;
      nhSync    = 1'b1;
      nvSync    = 1'b1;
      vidAck    = 1'b0;
      vidData   = '0;
      @(posedge pixClk);
      #1;

      // Reset held while every input toggles.
      $display("[TB] reset with toggling inputs");
      for (int i = 0; i < 3; i++) begin
         hCount    = 10'($urandom);
         vCount    = 10'($urandom);
         hActive   = 1'($urandom);
         vActive   = 1'($urandom);
         hSEActive = 1'($urandom);
         vSEActive = 1'($urandom);
         nhSync    = (i % 2 == 0) ? 1'b0 : 1'b1;
         nvSync    = (i % 2 == 0) ? 1'b0 : 1'b1;
         vidAck    = 1'b1;
         vidData   = 16'($urandom);
         @(negedge pixClk);
         checkOutput("rstVidReq",    16'(vidReq),    16'd0);
         checkOutput("rstVidAddr",   16'(vidAddr),   16'd0);
         checkOutput("rstPixOut",    16'(pixOut),    16'd0);
         checkOutput("rstNhSyncOut", 16'(nhSyncOut), 16'd1);
         checkOutput("rstNvSyncOut", 16'(nvSyncOut), 16'd1);
         checkOutput("rstUnderrun",  16'(underrun),  16'd0);
         @(posedge pixClk);
         #1;
      end
      reset  = 1'b0;
      vidAck = 1'b0;
      blankCycles(5, 10'd0);

      // Line 5: 32 fetches at 160..191, first word A5F0.
      $display("[TB] line 5 fetch and serialise");
      for (int w = 0; w < 32; w++) begin
         addrQ.push_back(14'(5 * 32 + w));
      end
      reqCount  = 0;
      pushCount = 0;
      popCount  = 0;
      maxBuf    = 0;
      ramEn     = 1'b1;
      lineStartSeq(10'd5);
      blankCycles(20, 10'd5);
      seWindow(32, 10'd5, 0);
      borderCycles(16, 10'd5);
      blankCycles(20, 10'd5);
      checkOutput("line5ReqCount", 16'(reqCount), 16'd32);
      checkOutput("line5AddrDone", 16'(addrQ.size()), 16'd0);
      checkOutput("line5MaxBuf",   16'(maxBuf), 16'd2);
      checkOutput("line5Underrun", 16'(underrun), 16'd0);

      // Line 400 lies beyond the SE area: no fetches, all white.
      $display("[TB] line 400 outside SE area");
      reqCount = 0;
      lineStartSeq(10'd400);
      blankCycles(6, 10'd400);
      seWindow(4, 10'd400, 2);
      borderCycles(8, 10'd400);
      blankCycles(6, 10'd400);
      checkOutput("line400ReqCount", 16'(reqCount), 16'd0);
      checkOutput("line400Underrun", 16'(underrun), 16'd0);

      // Line 7 with the RAM silent: the load finds the FIFO empty.
      $display("[TB] underrun on line 7");
      ramEn  = 1'b0;
      vidAck = 1'b0;
      addrQ.push_back(14'(7 * 32));
      lineStartSeq(10'd7);
      blankCycles(4, 10'd7);
      seWindow(1, 10'd7, 1);
      borderCycles(4, 10'd7);
      checkOutput("line7Underrun", 16'(underrun), 16'd1);
      checkOutput("line7ReqHeld",  16'(vidReq),   16'd1);

      // Line start while the line-7 request is still pending, then a late ack.
      $display("[TB] abort pending request with line 9 start");
      addrQ.push_back(14'(9 * 32));
      lineStartSeq(10'd9);
      @(negedge pixClk);
      checkOutput("abortReqDrop", 16'(vidReq), 16'd0);
      vidAck  = 1'b1;
      vidData = 16'h0000;
      applyStimulus(10'd700, 10'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      vidAck  = 1'b0;
      blankCycles(4, 10'd9);
      seWindow(1, 10'd9, 1);
      borderCycles(4, 10'd9);
      blankCycles(6, 10'd9);
      checkOutput("abortAddrDone",   16'(addrQ.size()), 16'd0);
      checkOutput("underrunSticky", 16'(underrun), 16'd1);

      // Let the pixel queue drain, then reset mid-request.
      repeat (4) begin
         @(posedge pixClk);
      end
      #1;
      checkOutput("pixQueueDrained", 16'(pixQ.size()), 16'd0);
      reset = 1'b1;
      @(posedge pixClk);
      #1;
      reset = 1'b0;
      @(negedge pixClk);
      checkOutput("finalRstVidReq",   16'(vidReq),   16'd0);
      checkOutput("finalRstUnderrun", 16'(underrun), 16'd0);
      checkOutput("finalRstPixOut",   16'(pixOut),   16'd0);
      repeat (4) begin
         @(posedge pixClk);
      end
      #1;
      checkOutput("finalNoReq", 16'(vidReq), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
